fp32_mul_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision multiplier controller.
- Accepts operand pairs over a valid/ready handshake and forms the 48-bit significand product with an iterative shift-add engine.
- Sequences normalisation, 23-bit mantissa rounding and exponent/sign packing through an FSM.
- Presents one packed result plus flags under output backpressure. One operation in flight at a time.

---
 rtl/fp32_mul_seq_if.sv | 25 ++
 rtl/fp32_mul_seq.sv | 143 ++++++++++++++
 tb/tb_fp32_mul_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_seq_if.sv
// fp32_mul_seq_if: operand/result handshake bundle for fp32_mul_seq
// Signals:
//   in_valid/in_ready/a/b               operand pair handshake (master -> slave)
//   out_valid/out_ready/result/flags    product handshake (slave -> master)
//   busy                                slave is working on an operation
// Modports: master = producer/consumer side, slave = multiplier side.
interface fp32_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq: multi-cycle IEEE-754 single-precision multiplier, one op in flight
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation
//   bus    fp32_mul_seq_if.slave: in_valid/in_ready/a/b in, out_valid/out_ready/
//          result/flags{invalid,overflow,underflow,inexact} out, busy
// Parameter BITS_PER_CYC: multiplier bits per MUL cycle (divisor of 24).
// Build option FP32_MUL_RNE_EN: round-to-nearest-even instead of round-half-up.
module fp32_mul_seq #(
    parameter int BITS_PER_CYC = 1
) (
    input logic           clk,
    input logic           rst_n,
    fp32_mul_seq_if.slave bus
);
    localparam int ITERS = 24 / BITS_PER_CYC;
    localparam logic [4:0] LAST = 5'(ITERS - 1);

    typedef enum logic [2:0] {IDLE, MUL, NORM, RND, OUT} state_t;
    state_t state, state_nx;

    logic               sign;
    logic signed [9:0]  esum;
    logic [23:0]        ma, mb;
    logic [47:0]        p;
    logic [4:0]         cnt;
    logic [22:0]        mant;
    logic               guard, sticky;
    logic [31:0]        res_q;
    logic [3:0]         flg_q;

    // operand classification, denormals count as zero
    logic [7:0]  ea, eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        is_nan, is_inf, special, sgn_in;
    logic [31:0] spec_res;
    assign ea       = bus.a[30:23];
    assign eb       = bus.b[30:23];
    assign a_nan    = (&ea) && (|bus.a[22:0]);
    assign b_nan    = (&eb) && (|bus.b[22:0]);
    assign a_inf    = (&ea) && !(|bus.a[22:0]);
    assign b_inf    = (&eb) && !(|bus.b[22:0]);
    assign a_zero   = ea == 8'd0;
    assign b_zero   = eb == 8'd0;
    assign sgn_in   = bus.a[31] ^ bus.b[31];
    assign is_nan   = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign is_inf   = a_inf || b_inf;
    assign special  = is_nan || is_inf || a_zero || b_zero;
    assign spec_res = is_nan ? 32'h7FC0_0000 : is_inf ? {sgn_in, 8'hFF, 23'd0} : {sgn_in, 31'd0};

    // shift-add: consume the multiplier MSB-first so no variable shifter is needed
    logic [BITS_PER_CYC-1:0]  chunk;
    logic [23+BITS_PER_CYC:0] pp;
    assign chunk = mb[23 -: BITS_PER_CYC];
    assign pp    = {{BITS_PER_CYC{1'b0}}, ma} * {24'd0, chunk};

    // rounding and packing
    logic              inc, carry, ovf, unf, inx;
    logic [22:0]       mant_r;
    logic signed [9:0] e_r;
    logic [31:0]       rnd_res;
`ifdef FP32_MUL_RNE_EN
    assign inc = guard && (sticky || mant[0]);
`else
    assign inc = guard;
`endif
    assign {carry, mant_r} = {1'b0, mant} + {23'd0, inc};
    assign e_r     = esum + {9'd0, carry};
    assign ovf     = e_r >= 10'sd255;
    assign unf     = e_r <= 10'sd0;
    assign inx     = guard || sticky || ovf || unf;
    assign rnd_res = ovf ? {sign, 8'hFF, 23'd0} : unf ? {sign, 31'd0} : {sign, e_r[7:0], mant_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? (special ? OUT : MUL) : IDLE;
            MUL:     state_nx = (cnt == LAST) ? NORM : MUL;
            NORM:    state_nx = RND;
            RND:     state_nx = OUT;
            OUT:     state_nx = bus.out_ready ? IDLE : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            esum   <= '0;
            ma     <= '0;
            mb     <= '0;
            p      <= '0;
            cnt    <= '0;
            mant   <= '0;
            guard  <= 1'b0;
            sticky <= 1'b0;
            res_q  <= '0;
            flg_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign <= sgn_in;
                    esum <= $signed({2'b0, ea} + {2'b0, eb} - 10'd127);
                    ma   <= {1'b1, bus.a[22:0]};
                    mb   <= {1'b1, bus.b[22:0]};
                    p    <= '0;
                    cnt  <= '0;
                    if (special) begin
                        res_q <= spec_res;
                        flg_q <= {is_nan, 3'b000};
                    end
                end
                MUL: begin
                    p   <= (p << BITS_PER_CYC) + 48'(pp);
                    mb  <= mb << BITS_PER_CYC;
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    mant   <= p[47] ? p[46:24] : p[45:23];
                    guard  <= p[47] ? p[23] : p[22];
                    sticky <= p[47] ? |p[22:0] : |p[21:0];
                    esum   <= esum + {9'd0, p[47]};
                end
                RND: begin
                    res_q <= rnd_res;
                    flg_q <= {1'b0, ovf, unf, inx};
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == OUT;
    assign bus.busy      = state != IDLE;
    assign bus.result    = res_q;
    assign bus.flags     = flg_q;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb_fp32_mul_seq: scoreboard bench for fp32_mul_seq with directed vectors
module tb_fp32_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp32_mul_seq_if bus();
    fp32_mul_seq #(.BITS_PER_CYC(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef FP32_MUL_RNE_EN
    localparam logic [31:0] TIE = 32'h3FC0_0004;
`else
    localparam logic [31:0] TIE = 32'h3FC0_0005;
`endif

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit seen    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: latency on first out_valid cycle, result/flags on transfer
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h with no op pending", bus.result);
            end else begin
                if (!seen) begin
                    check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    seen = 1'b1;
                end
                if (bus.out_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", bus.result, e.res);
                    check("flags", {28'd0, bus.flags}, {28'd0, e.flg});
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] res, input logic [3:0] flg, input int lat);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at %b, required 1", bus.in_ready);
        end else begin
            q.push_back('{res, flg, lat, cyc});
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain;
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d ops pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", {28'd0, bus.flags}, 32'd0);
        rst_n = 1'b1;

        send(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'h0, 27);
        send(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'h8, 1);
        send(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'h0, 1);
        send(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'h5, 27);
        send(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'h3, 27);
        send(32'h3F80_0003, 32'h3FC0_0000, TIE,           4'h1, 27);
        send(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 4'h0, 1);
        send(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'h8, 1);
        send(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'h0, 27);
        send(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 4'h0, 27);
        send(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'h0, 1);
        drain();

        // backpressure: hold OUT, a second request must be ignored meanwhile
        bus.out_ready = 1'b0;
        send(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'h0, 27);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        bus.in_valid = 1'b1;
        bus.a = 32'h3FC0_0000;
        bus.b = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_result", bus.result, 32'h4110_0000);
            check("bp_flags", {28'd0, bus.flags}, 32'd0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'h0, 27);
        drain();

        // reset in the middle of MUL aborts the op
        send(32'h4040_0000, 32'h3FC0_0000, 32'h4090_0000, 4'h0, 27);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_flags", {28'd0, bus.flags}, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(32'h4040_0000, 32'h3FC0_0000, 32'h4090_0000, 4'h0, 27);
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
